// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - chart step sequencer: tick edge detect, chart ROM fetch, per-lane spawn pulses
module beat_sequencer #(
    parameter int STEPS = 256,
    parameter int AW    = 8,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             start,
    input  logic             pause,
    output logic [AW-1:0]    chart_addr,
    input  logic [LANES-1:0] chart_data,
    output logic [LANES-1:0] spawn,
    output logic             beat_pulse,
    output logic [AW-1:0]    step,
    output logic             playing,
    output logic             song_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] step_next;
    logic          tick_d;
    logic          rd_pending;
    logic          rd_next;
    logic          rise;
    logic          at_last;

    assign rise    = tick_in & ~tick_d;
    assign at_last = (step == LAST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pending read always completes; only a RUN consume of the last step ends the song.
    always_comb begin
        state_next = state;
        step_next  = step;
        rd_next    = rd_pending;

        if (rd_pending) begin
            rd_next = 1'b0;
            if (!at_last) begin
                step_next = step + 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    step_next  = '0;
                end
            end
            S_RUN: begin
                if (pause) begin
                    state_next = S_PAUSED;
                end else begin
                    if (rise) begin
                        rd_next = 1'b1;
                    end
                    if (rd_pending && at_last) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_PAUSED: begin
                if (!pause && start) begin
                    state_next = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    step_next  = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // chart_addr is a second register loaded with the same value as step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step       <= '0;
            chart_addr <= '0;
            tick_d     <= 1'b0;
            rd_pending <= 1'b0;
            spawn      <= '0;
            beat_pulse <= 1'b0;
        end else begin
            step       <= step_next;
            chart_addr <= step_next;
            tick_d     <= tick_in;
            rd_pending <= rd_next;
            spawn      <= rd_pending ? chart_data : '0;
            beat_pulse <= rd_pending;
        end
    end

    always_comb begin
        playing   = (state == S_RUN);
        song_done = (state == S_DONE);
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - directed vector bench for beat_sequencer with a 4-step chart
module tb_beat_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic [1:0] chart_addr;
    logic [1:0] chart_data;
    logic [1:0] spawn;
    logic       beat_pulse;
    logic [1:0] step;
    logic       playing;
    logic       song_done;

    int checks = 0;
    int errors = 0;

    logic [1:0] rom [0:3];

    beat_sequencer #(.STEPS(4), .AW(2), .LANES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .start      (start),
        .pause      (pause),
        .chart_addr (chart_addr),
        .chart_data (chart_data),
        .spawn      (spawn),
        .beat_pulse (beat_pulse),
        .step       (step),
        .playing    (playing),
        .song_done  (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chart_data <= rom[chart_addr];

    typedef struct {
        logic       tick;
        logic       st;
        logic       pa;
        int         n;
        logic [1:0] sp;
        logic       bt;
        logic [1:0] stp;
        logic       pl;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic t, logic st, logic pa, int n, logic [1:0] sp,
                                logic bt, logic [1:0] stp, logic pl, logic dn);
        vec_t v;
        v.tick = t; v.st = st; v.pa = pa; v.n = n;
        v.sp = sp; v.bt = bt; v.stp = stp; v.pl = pl; v.dn = dn;
        vecs.push_back(v);
    endfunction

    // One 8-clk tick period while running: rise, consume, then idle cycles.
    function automatic void add_period(logic [1:0] sp, logic [1:0] sb, logic [1:0] sa, logic fin);
        add(1, 0, 0, 1, 2'b00, 0, sb, 1, 0);
        add(1, 0, 0, 1, sp, 1, sa, !fin, fin);
        add(1, 0, 0, 2, 2'b00, 0, sa, !fin, fin);
        add(0, 0, 0, 4, 2'b00, 0, sa, !fin, fin);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d, t=%0t): got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic chk_all(int idx, logic [1:0] sp, logic bt, logic [1:0] stp, logic pl, logic dn);
        chk("spawn", idx, 32'(spawn), 32'(sp));
        chk("beat_pulse", idx, 32'(beat_pulse), 32'(bt));
        chk("step", idx, 32'(step), 32'(stp));
        chk("chart_addr", idx, 32'(chart_addr), 32'(stp));
        chk("playing", idx, 32'(playing), 32'(pl));
        chk("song_done", idx, 32'(song_done), 32'(dn));
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                tick_in = vecs[i].tick;
                start   = vecs[i].st;
                pause   = vecs[i].pa;
                @(posedge clk);
                #1;
                chk_all(i, vecs[i].sp, vecs[i].bt, vecs[i].stp, vecs[i].pl, vecs[i].dn);
            end
        end
        vecs.delete();
    endtask

    initial begin
        rom[0] = 2'b01;
        rom[1] = 2'b00;
        rom[2] = 2'b11;
        rom[3] = 2'b10;
        rst_n   = 1'b0;
        tick_in = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 2'b00, 0, 2'd0, 0, 0);
        rst_n = 1'b1;

        // start while tick_in is already high: no spurious step
        add(1, 0, 0, 3, 2'b00, 0, 0, 0, 0);
        add(1, 1, 0, 1, 2'b00, 0, 0, 1, 0);
        add(1, 0, 0, 3, 2'b00, 0, 0, 1, 0);
        add(0, 0, 0, 4, 2'b00, 0, 0, 1, 0);
        add_period(2'b01, 0, 1, 0);
        add_period(2'b00, 1, 2, 0);
        add_period(2'b11, 2, 3, 0);
        add_period(2'b10, 3, 3, 1);
        // DONE ignores ticks and pause
        add(1, 0, 1, 4, 2'b00, 0, 3, 0, 1);
        add(0, 0, 0, 4, 2'b00, 0, 3, 0, 1);
        // restart from DONE
        add(0, 1, 0, 1, 2'b00, 0, 0, 1, 0);
        add_period(2'b01, 0, 1, 0);
        add_period(2'b00, 1, 2, 0);
        // pause for three tick periods, then start+pause together, then resume
        add(0, 0, 1, 1, 2'b00, 0, 2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 1, 4, 2'b00, 0, 2, 0, 0);
            add(0, 0, 1, 4, 2'b00, 0, 2, 0, 0);
        end
        add(0, 1, 1, 2, 2'b00, 0, 2, 0, 0);
        add(0, 1, 0, 1, 2'b00, 0, 2, 1, 0);
        add(0, 0, 0, 2, 2'b00, 0, 2, 1, 0);
        add_period(2'b11, 2, 3, 0);
        // pause on the consume edge of the last step: beat delivered, PAUSED wins
        add(1, 0, 0, 1, 2'b00, 0, 3, 1, 0);
        add(1, 0, 1, 1, 2'b10, 1, 3, 0, 0);
        add(1, 0, 1, 2, 2'b00, 0, 3, 0, 0);
        add(0, 0, 1, 4, 2'b00, 0, 3, 0, 0);
        add(1, 0, 0, 4, 2'b00, 0, 3, 0, 0);
        add(0, 0, 0, 4, 2'b00, 0, 3, 0, 0);
        add(0, 1, 0, 1, 2'b00, 0, 3, 1, 0);
        add(0, 0, 0, 3, 2'b00, 0, 3, 1, 0);
        add_period(2'b10, 3, 3, 1);
        run_vecs();

        // reset while a read is pending
        add(0, 1, 0, 1, 2'b00, 0, 0, 1, 0);
        add(0, 0, 0, 2, 2'b00, 0, 0, 1, 0);
        add(1, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        run_vecs();
        rst_n = 1'b0;
        #2;
        chk_all(-2, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add(1, 0, 0, 3, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 4, 2'b00, 0, 0, 0, 0);
        add(1, 0, 0, 4, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 4, 2'b00, 0, 0, 0, 0);
        // reset truncates a spawn pulse in progress
        add(0, 1, 0, 1, 2'b00, 0, 0, 1, 0);
        add(1, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        add(1, 0, 0, 1, 2'b01, 1, 1, 1, 0);
        run_vecs();
        rst_n = 1'b0;
        #2;
        chk_all(-3, 2'b00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add(1, 0, 0, 2, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 2, 2'b00, 0, 0, 0, 0);
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
